double_counter: RTL and testbench

DOUBLE_COUNTER -- requirements
Module: double_counter

---
 rtl/double_counter.sv | 73 +++++++
 tb/tb_double_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/double_counter.sv
// Row-major (u,v) position counter over a BLOCK_SIZE x BLOCK_SIZE block.
// Define DOUBLE_COUNTER_WRAP_EN to wrap to (0,0) after the final position instead of saturating.
module double_counter #(
  parameter int unsigned BLOCK_SIZE = 8,
  parameter int unsigned CNT_W      = $clog2(BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             go,
  output logic [CNT_W-1:0] u,
  output logic [CNT_W-1:0] v,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE - 1);

  logic [CNT_W-1:0] r_u;
  logic [CNT_W-1:0] r_v;
  logic [CNT_W-1:0] w_u_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_u_last;
  logic             w_v_last;
  logic             w_final;
  logic             w_step;
  logic             w_u_en;
  logic             w_v_en;

  assign w_u_last = (r_u == LAST);
  assign w_v_last = (r_v == LAST);
  assign w_final  = w_u_last && w_v_last;

`ifdef DOUBLE_COUNTER_WRAP_EN
  assign w_step = go;
`else
  // Saturate: suppress stepping once the final position is reached.
  assign w_step = go && !w_final;
`endif

  assign w_v_en = restart || w_step;
  assign w_u_en = restart || (w_step && w_v_last);

  // Explicit compare-to-LAST wrap keeps values in range for non-power-of-two sizes.
  always_comb begin
    w_u_nxt = '0;
    w_v_nxt = '0;
    if (!restart) begin
      w_v_nxt = w_v_last ? '0 : r_v + CNT_W'(1);
      w_u_nxt = w_u_last ? '0 : r_u + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (w_v_en) begin
      r_v <= w_v_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u <= '0;
    end else if (w_u_en) begin
      r_u <= w_u_nxt;
    end
  end

  assign u    = r_u;
  assign v    = r_v;
  assign done = w_final;

endmodule

// File: tb/tb_double_counter.sv
// Randomized and directed checks of double_counter (BLOCK_SIZE 8 and 5) against a linear-index model.
module tb_double_counter;

  logic       clk;
  logic       rst_n;
  logic       restart;
  logic       go;
  logic [2:0] u8, v8, u5, v5;
  logic       done8, done5;

  int n_cmp;
  int n_bad;
  int p8;
  int p5;

`ifdef DOUBLE_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  double_counter #(.BLOCK_SIZE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .go(go),
    .u(u8), .v(v8), .done(done8)
  );

  double_counter #(.BLOCK_SIZE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .restart(restart), .go(go),
    .u(u5), .v(v5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position as a single row-major index; u = p / n, v = p % n.
  function automatic int model_next(input int p, input int n, input bit rs,
                                    input bit r, input bit g);
    if (!rs) return 0;
    if (r) return 0;
    if (g) begin
      if (p < n * n - 1) return p + 1;
      return WRAP ? 0 : p;
    end
    return p;
  endfunction

  task automatic check_all();
    check("u8", int'(u8), p8 / 8);
    check("v8", int'(v8), p8 % 8);
    check("done8", int'(done8), (p8 == 63) ? 1 : 0);
    check("u5", int'(u5), p5 / 5);
    check("v5", int'(v5), p5 % 5);
    check("done5", int'(done5), (p5 == 24) ? 1 : 0);
    check("range5", (u5 <= 3'd4 && v5 <= 3'd4) ? 1 : 0, 1);
  endtask

  task automatic step(input bit g, input bit r);
    go      = g;
    restart = r;
    @(posedge clk);
    p8 = model_next(p8, 8, rst_n, r, g);
    p5 = model_next(p5, 5, rst_n, r, g);
    #1;
    check_all();
  endtask

  int pulses;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    p8      = 0;
    p5      = 0;
    rst_n   = 1'b0;
    restart = 1'b0;
    go      = 1'b0;
    #1;
    check_all();
    step(1'b1, 1'b0);
    rst_n = 1'b1;

    // Full pass from a restart with go held
    step(1'b0, 1'b1);
    for (int i = 1; i <= 73; i++) begin
      step(1'b1, 1'b0);
      if (i == 23) check("done5_pre", int'(done5), 0);
      if (i == 24) check("done5_at24", int'(done5), 1);
      if (i == 62) check("done8_pre", int'(done8), 0);
      if (i == 63) begin
        check("done8_at63", int'(done8), 1);
        check("u8_at63", int'(u8), 7);
        check("v8_at63", int'(v8), 7);
      end
      if (!WRAP && i > 63) check("sat8", {29'd0, u8} * 8 + {29'd0, v8}, 63);
    end

    // Hold: from (0,6), go = 1,0,0,1
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0); check("hold_a", {29'd0, u8} * 8 + {29'd0, v8}, 7);
    step(1'b0, 1'b0); check("hold_b", {29'd0, u8} * 8 + {29'd0, v8}, 7);
    step(1'b0, 1'b0); check("hold_c", {29'd0, u8} * 8 + {29'd0, v8}, 7);
    step(1'b1, 1'b0); check("hold_d", {29'd0, u8} * 8 + {29'd0, v8}, 8);

    // Priority: restart beats go at (4,2)
    step(1'b0, 1'b1);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0);
    check("at_4_2", {29'd0, u8} * 8 + {29'd0, v8}, 34);
    step(1'b1, 1'b1);
    check("prio", {29'd0, u8} * 8 + {29'd0, v8}, 0);

    // Asynchronous reset mid-count at (3,5), no clock edge
    for (int i = 0; i < 29; i++) step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    p8 = 0;
    p5 = 0;
    check("arst_u", int'(u8), 0);
    check("arst_v", int'(v8), 0);
    check("arst_done", int'(done8), 0);
    check_all();
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    check("post_rst", {29'd0, u8} * 8 + {29'd0, v8}, 1);

    if (WRAP) begin
      step(1'b0, 1'b1);
      pulses = 0;
      for (int i = 1; i <= 130; i++) begin
        step(1'b1, 1'b0);
        if (done8) pulses++;
        if (i == 64) check("wrap64", {29'd0, u8} * 8 + {29'd0, v8}, 0);
      end
      check("wrap_pulses", pulses, 2);
    end

    // Randomized mix of go, restart and occasional reset
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      step(($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
